// File: rtl/water_pkg.sv
// Shared types and helpers for the tank pump controller.
//   state_t      : controller state, encoded as reported on the state output
//   LVL_W        : width of the thermometer-coded indicator bus
//   LEVEL_W      : width of the binary level count (0..5)
//   therm_valid  : 1 when a code is a legal thermometer code (ones packed at bit 0)
//   therm_count  : number of ones in a code
package water_pkg;

    localparam int LVL_W   = 5;
    localparam int LEVEL_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRY   = 2'd2,
        FAULT = 2'd3
    } state_t;

    // A thermometer code plus one is a single power of two (or wraps to zero),
    // so it shares no set bit with the original code.
    function automatic logic therm_valid(input logic [LVL_W-1:0] code);
        return (code & (code + LVL_W'(1))) == '0;
    endfunction

    function automatic logic [LEVEL_W-1:0] therm_count(input logic [LVL_W-1:0] code);
        logic [LEVEL_W-1:0] n;
        n = '0;
        for (int unsigned i = 0; i < LVL_W; i++) begin
            n = n + LEVEL_W'(code[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/lvl_debounce.sv
// Synchroniser and debouncer for the level-indicator lines.
//   clk, rst : clock, asynchronous active-high reset
//   lvl_in   : raw indicator lines (bit 0 = lowest level)
//   code     : accepted (debounced) code, may be illegal
//   level    : count of ones in the last accepted legal code
//   lvl_vld  : set on the first accepted code, held until reset
// A code is accepted once the synchronised value has matched the previous
// cycle's value DEB_CYCLES times in a row and differs from the accepted code.
module lvl_debounce
    import water_pkg::*;
#(
    parameter int DEB_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [LVL_W-1:0]   lvl_in,
    output logic [LVL_W-1:0]   code,
    output logic [LEVEL_W-1:0] level,
    output logic               lvl_vld
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic [LVL_W-1:0] sync1;
    logic [LVL_W-1:0] sync2;
    logic [LVL_W-1:0] prev;
    logic [CW-1:0]    cnt;
    logic             stable;
    logic             accept;

    assign stable = (sync2 == prev);
    // cnt holds the number of earlier consecutive stable cycles, so the
    // DEB_CYCLES-th stable cycle is the one seen with cnt at CNT_MAX.
    assign accept = stable && (cnt == CNT_MAX) && (sync2 != code);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= '0;
            sync2   <= '0;
            prev    <= '0;
            cnt     <= '0;
            code    <= '0;
            level   <= '0;
            lvl_vld <= 1'b0;
        end else begin
            sync1 <= lvl_in;
            sync2 <= sync1;
            prev  <= sync2;
            if (!stable) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CW'(1);
            end
            if (accept) begin
                code    <= sync2;
                lvl_vld <= 1'b1;
                // An illegal code leaves the last legal level in place.
                if (therm_valid(sync2)) begin
                    level <= therm_count(sync2);
                end
            end
        end
    end

endmodule

// File: rtl/tank_pump_ctrl.sv
// Hysteresis pump controller with overflow, dry-run and sensor-fault alarms.
//   clk, rst     : clock, asynchronous active-high reset
//   lvl_in       : raw level-indicator lines (thermometer code, bit 0 lowest)
//   clr          : one-cycle acknowledge of a dry-run alarm (only used in DRY)
//   pump_on      : pump drive
//   level        : accepted level 0..5
//   overflow     : accepted level is 5
//   dry_alarm    : dry-run latched
//   sensor_fault : accepted code is not a thermometer code
//   state        : 0 IDLE, 1 FILL, 2 DRY, 3 FAULT
module tank_pump_ctrl
    import water_pkg::*;
#(
    parameter int DEB_CYCLES   = 16,
    parameter int FILL_TIMEOUT = 1000000,
    parameter int LOW_MARK     = 1,
    parameter int HIGH_MARK    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [LVL_W-1:0]   lvl_in,
    input  logic               clr,
    output logic               pump_on,
    output logic [LEVEL_W-1:0] level,
    output logic               overflow,
    output logic               dry_alarm,
    output logic               sensor_fault,
    output logic [1:0]         state
);

    localparam int TW = $clog2(FILL_TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(FILL_TIMEOUT - 1);

    logic [LVL_W-1:0]   acc_code;
    logic               lvl_vld;
    logic [LEVEL_W-1:0] level_d;
    logic               lvl_up;
    logic               code_bad;
    logic               ovf_c;
    state_t             st;
    state_t             st_nxt;
    logic [TW-1:0]      tcnt;
    logic [TW-1:0]      tcnt_nxt;
    logic               dry_nxt;

    lvl_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
        .clk     (clk),
        .rst     (rst),
        .lvl_in  (lvl_in),
        .code    (acc_code),
        .level   (level),
        .lvl_vld (lvl_vld)
    );

    // level only moves on an accepted code, so a rise is visible for exactly
    // one cycle against the previous cycle's level.
    assign lvl_up   = (level > level_d);
    assign code_bad = !therm_valid(acc_code);
    assign ovf_c    = lvl_vld && (level == LEVEL_W'(5));
    assign state    = st;

    always_comb begin
        st_nxt   = st;
        tcnt_nxt = tcnt;
        dry_nxt  = dry_alarm;
        if (lvl_vld) begin
            if (code_bad) begin
                st_nxt = FAULT;
            end else begin
                case (st)
                    IDLE: begin
                        if (level <= LEVEL_W'(LOW_MARK)) begin
                            st_nxt   = FILL;
                            tcnt_nxt = '0;
                        end
                    end
                    FILL: begin
                        if (ovf_c) begin
                            st_nxt = IDLE;
                        end else if (!lvl_up && (tcnt == TO_LAST)) begin
                            // FILL_TIMEOUT cycles without a rise; tcnt is left
                            // at its last value (saturated) until FILL is re-entered.
                            st_nxt  = DRY;
                            dry_nxt = 1'b1;
                        end else if (level >= LEVEL_W'(HIGH_MARK)) begin
                            st_nxt = IDLE;
                        end else if (lvl_up) begin
                            tcnt_nxt = '0;
                        end else begin
                            tcnt_nxt = tcnt + TW'(1);
                        end
                    end
                    DRY: begin
                        if (clr) begin
                            st_nxt  = IDLE;
                            dry_nxt = 1'b0;
                        end
                    end
                    FAULT: begin
                        st_nxt = IDLE;
                    end
                    default: begin
                        st_nxt = IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st           <= IDLE;
            tcnt         <= '0;
            level_d      <= '0;
            pump_on      <= 1'b0;
            overflow     <= 1'b0;
            dry_alarm    <= 1'b0;
            sensor_fault <= 1'b0;
        end else begin
            st           <= st_nxt;
            tcnt         <= tcnt_nxt;
            level_d      <= level;
            pump_on      <= (st_nxt == FILL);
            overflow     <= ovf_c;
            dry_alarm    <= dry_nxt;
            sensor_fault <= code_bad;
        end
    end

endmodule

// File: tb/tb_tank_pump_ctrl.sv
// Testbench for tank_pump_ctrl: directed table, hand sequences for latency and
// asynchronous reset, and random stimulus compared every cycle against a
// history-based reference model.
module tb_tank_pump_ctrl;

    localparam int DEB  = 4;
    localparam int TO   = 50;
    localparam int LOW  = 1;
    localparam int HIGH = 4;

    localparam int M_IDLE  = 0;
    localparam int M_FILL  = 1;
    localparam int M_DRY   = 2;
    localparam int M_FAULT = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic [4:0] lvl_in;
    logic       pump_on;
    logic [2:0] level;
    logic       overflow;
    logic       dry_alarm;
    logic       sensor_fault;
    logic [1:0] state;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    tank_pump_ctrl #(
        .DEB_CYCLES  (DEB),
        .FILL_TIMEOUT(TO),
        .LOW_MARK    (LOW),
        .HIGH_MARK   (HIGH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .lvl_in      (lvl_in),
        .clr         (clr),
        .pump_on     (pump_on),
        .level       (level),
        .overflow    (overflow),
        .dry_alarm   (dry_alarm),
        .sensor_fault(sensor_fault),
        .state       (state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    logic [4:0] legal_tab [6] = '{5'b00000, 5'b00001, 5'b00011, 5'b00111, 5'b01111, 5'b11111};

    logic [4:0] hist [$];   // hist[0] = input sampled at the latest edge
    logic [4:0] m_acc;
    int         m_level, m_st, m_fill;
    bit         m_vld, m_rose, m_pump, m_dry, m_ovf, m_flt;

    function automatic int legal_level(input logic [4:0] c);
        for (int i = 0; i < 6; i++) if (legal_tab[i] == c) return i;
        return -1;
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < DEB + 3; i++) hist.push_back(5'b0);
        m_acc = '0; m_level = 0; m_st = M_IDLE; m_fill = 0;
        m_vld = 0; m_rose = 0; m_pump = 0; m_dry = 0; m_ovf = 0; m_flt = 0;
    endtask

    task automatic model_step(input logic [4:0] din, input logic c);
        bit same;
        int nl;
        // controller reacts to what was accepted before this edge
        if (m_vld) begin
            if (legal_level(m_acc) < 0) m_st = M_FAULT;
            else case (m_st)
                M_IDLE: if (m_level <= LOW) begin m_st = M_FILL; m_fill = 0; end
                M_FILL: begin
                    if (m_level == 5) m_st = M_IDLE;
                    else if (!m_rose && m_fill + 1 == TO) begin m_st = M_DRY; m_dry = 1; end
                    else if (m_level >= HIGH) m_st = M_IDLE;
                    else if (m_rose) m_fill = 0;
                    else m_fill++;
                end
                M_DRY: if (c) begin m_st = M_IDLE; m_dry = 0; end
                default: m_st = M_IDLE;
            endcase
        end
        m_pump = (m_st == M_FILL);
        m_ovf  = m_vld && (m_level == 5);
        m_flt  = (legal_level(m_acc) < 0);
        // debounce: the synchronised value seen now is the input of two edges ago;
        // accept when it and the DEB values before it all agree
        hist.push_front(din);
        void'(hist.pop_back());
        same = 1;
        for (int i = 3; i <= 2 + DEB; i++) if (hist[i] != hist[2]) same = 0;
        m_rose = 0;
        if (same && hist[2] != m_acc) begin
            m_acc = hist[2];
            m_vld = 1;
            nl = legal_level(m_acc);
            if (nl >= 0) begin
                m_rose  = (nl > m_level);
                m_level = nl;
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_step(lvl_in, clr);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("mdl_pump",  pump_on,      m_pump);
            check("mdl_level", level,        m_level);
            check("mdl_state", state,        m_st);
            check("mdl_ovf",   overflow,     m_ovf);
            check("mdl_dry",   dry_alarm,    m_dry);
            check("mdl_fault", sensor_fault, m_flt);
        end
    end

    // ---------------- directed table ----------------
    typedef struct {
        logic [4:0] lvl;
        int         hold;
        logic       clr;
        int         e_level;
        int         e_state;
        logic       e_pump;
        logic       e_dry;
        logic       e_flt;
        logic       e_ovf;
    } vec_t;

    vec_t vecs [$];

    function automatic vec_t mk(input logic [4:0] l, input int h, input logic c, input int el,
                                input int es, input logic ep, input logic ed, input logic ef,
                                input logic eo);
        vec_t v;
        v.lvl = l; v.hold = h; v.clr = c; v.e_level = el; v.e_state = es;
        v.e_pump = ep; v.e_dry = ed; v.e_flt = ef; v.e_ovf = eo;
        return v;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_pump"},  pump_on,      0);
        check({tag, "_level"}, level,        0);
        check({tag, "_ovf"},   overflow,     0);
        check({tag, "_dry"},   dry_alarm,    0);
        check({tag, "_fault"}, sensor_fault, 0);
        check({tag, "_state"}, state,        0);
    endtask

    initial begin
        logic [4:0] code;
        int         r, hold;

        // rising steps in FILL, then back to IDLE at level 4
        vecs.push_back(mk(5'b00011, 20, 0, 2, M_FILL, 1, 0, 0, 0));
        vecs.push_back(mk(5'b00111, 20, 0, 3, M_FILL, 1, 0, 0, 0));
        vecs.push_back(mk(5'b01111, 20, 0, 4, M_IDLE, 0, 0, 0, 0));
        // fast toggling never gets accepted
        for (int i = 0; i < 14; i++)
            vecs.push_back(mk((i % 2 == 0) ? 5'b00001 : 5'b00011, 3, 0, 4, M_IDLE, 0, 0, 0, 0));
        // low level: fill, then stall into dry-run, acknowledge, refill
        vecs.push_back(mk(5'b00001, 10, 0, 1, M_FILL, 1, 0, 0, 0));
        vecs.push_back(mk(5'b00001, 60, 0, 1, M_DRY,  0, 1, 0, 0));
        vecs.push_back(mk(5'b00001,  1, 1, 1, M_IDLE, 0, 0, 0, 0));
        vecs.push_back(mk(5'b00001,  1, 0, 1, M_FILL, 1, 0, 0, 0));
        // illegal code, recovery, overflow, refill
        vecs.push_back(mk(5'b00101, 10, 0, 1, M_FAULT, 0, 0, 1, 0));
        vecs.push_back(mk(5'b00111, 10, 0, 3, M_IDLE,  0, 0, 0, 0));
        vecs.push_back(mk(5'b11111, 10, 0, 5, M_IDLE,  0, 0, 0, 1));
        vecs.push_back(mk(5'b00001, 10, 0, 1, M_FILL,  1, 0, 0, 0));

        // reset state
        rst = 1'b1; clr = 1'b0; lvl_in = 5'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");

        // first acceptance latency: edge 0 is the first edge after release
        rst = 1'b0; lvl_in = 5'b00001;
        repeat (6) @(negedge clk);
        check("lat_e5_level", level, 0);
        @(negedge clk);
        check("lat_e6_level", level, 1);
        check("lat_e6_pump",  pump_on, 0);
        check("lat_e6_state", state, M_IDLE);
        @(negedge clk);
        check("lat_e7_state", state, M_FILL);
        check("lat_e7_pump",  pump_on, 1);

        foreach (vecs[i]) begin
            lvl_in = vecs[i].lvl;
            clr    = vecs[i].clr;
            @(negedge clk);
            clr = 1'b0;
            repeat (vecs[i].hold - 1) @(negedge clk);
            check($sformatf("vec%0d_level", i), level,        vecs[i].e_level);
            check($sformatf("vec%0d_state", i), state,        vecs[i].e_state);
            check($sformatf("vec%0d_pump",  i), pump_on,      vecs[i].e_pump);
            check($sformatf("vec%0d_dry",   i), dry_alarm,    vecs[i].e_dry);
            check($sformatf("vec%0d_fault", i), sensor_fault, vecs[i].e_flt);
            check($sformatf("vec%0d_ovf",   i), overflow,     vecs[i].e_ovf);
        end

        // asynchronous reset in the middle of a fill cycle
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_all_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("rst_refill_e5_pump",  pump_on, 0);
        check("rst_refill_e5_level", level, 0);
        repeat (2) @(negedge clk);
        check("rst_refill_e7_state", state, M_FILL);
        check("rst_refill_e7_pump",  pump_on, 1);

        // random stimulus, checked every cycle against the model
        for (int it = 0; it < 150; it++) begin
            r = $urandom_range(0, 11);
            if (r <= 5)       code = legal_tab[r];
            else if (r <= 8)  code = legal_tab[$urandom_range(0, 2)];
            else if (r == 9)  code = 5'($urandom);
            else              code = legal_tab[$urandom_range(3, 5)];
            lvl_in = code;
            hold = $urandom_range(1, 40);
            for (int c = 0; c < hold; c++) begin
                clr = ($urandom_range(0, 15) == 0);
                @(negedge clk);
            end
            clr = 1'b0;
            if ($urandom_range(0, 39) == 0) begin
                @(posedge clk);
                #3 rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
